ack_eof_sequencer: RTL
======================

// Module: ack_eof_sequencer
// PURPOSE
//  Frame-tail field sequencer of the CAN receive path, clocked on the sample point SP.
//  - Starts on the CRC-delimiter indication from the CRC stage.
//  - Walks the ACK slot, ACK delimiter, EOF and intermission bits.
//  - Feeds EOF_Flag straight into EOF_Error_Block.
//  - Flags ACK errors, overload conditions and early SOF; reports frame completion.
// PARAMETERS
//  EOF_LEN  7  number of EOF bits (CAN fixed)
//  IFS_LEN  3  number of intermission bits
//  CNT_W    3  bit-counter width; must satisfy 2**CNT_W >= max(EOF_LEN,IFS_LEN)
// PORTS
//  SP              in   1  sample-point clock; all state changes on posedge SP
//  reset           in   1  synchronous, active-high reset
//  RX              in   1  sampled bus bit (0 = dominant, 1 = recessive)
//  CRC_Delim_Flag  in   1  high in the SP cycle whose RX bit is the CRC delimiter
//  Error_Abort     in   1  OR of downstream errors (incl. EOF_Error); forces IDLE
//  EOF_Flag        out  1  high for the one SP cycle whose RX bit is the ACK delimiter
//  In_EOF          out  1  high while RX bits belong to EOF
//  ACK_Error       out  1  1-cycle pulse: ACK slot was recessive
//  ACK_Delim_Error out  1  1-cycle pulse: ACK delimiter was dominant
//  Overload        out  1  1-cycle pulse: dominant bit in IFS bit 1..IFS_LEN-1
//  SOF_Detect      out  1  1-cycle pulse: dominant bit in the last IFS bit
//  Frame_Done      out  1  1-cycle pulse: IFS completed recessive
//  State           out  3  current state encoding (debug / verification)
// BEHAVIOUR
//  - Reset: state = IDLE, counter = 0, every output = 0.
//  - Priority at each edge: reset > Error_Abort > normal transitions.
//  - All outputs are registered. A pulse is asserted in the cycle after the edge
//    that sampled its cause.
//  - States: IDLE, ACK_SLOT, ACK_DELIM, EOF, IFS.
//  - IDLE: CRC_Delim_Flag=1 -> ACK_SLOT. All other inputs are ignored.
//  - ACK_SLOT: one bit.
//    - RX=1 -> ACK_Error pulse.
//    - Always -> ACK_DELIM. ACK error is flag-only; the sequence does not abort.
//  - ACK_DELIM: one bit. EOF_Flag=1 for the whole state, set on entry, cleared on exit.
//    - RX=0 -> ACK_Delim_Error pulse, -> IDLE.
//    - RX=1 -> EOF, counter cleared.
//  - EOF:
//    - In_EOF=1 for all EOF bits.
//    - Counter increments per edge. RX is not checked here; EOF_Error_Block checks it.
//    - Counter==EOF_LEN-1 -> IFS, counter cleared.
//  - IFS:
//    - RX=0 with counter<IFS_LEN-1 -> Overload pulse, -> IDLE.
//    - RX=0 with counter==IFS_LEN-1 -> SOF_Detect pulse, -> IDLE.
//    - RX=1 with counter==IFS_LEN-1 -> Frame_Done pulse, -> IDLE.
//  - Latency: CRC delimiter edge k, ACK slot edge k+1, ACK delimiter edge k+2.
//    - EOF bits occupy edges k+3..k+2+EOF_LEN.
//    - Frame_Done rises after edge k+2+EOF_LEN+IFS_LEN.
//  - Error_Abort in any state: -> IDLE, counter cleared, EOF_Flag/In_EOF dropped on that edge.
//    - Same edge as CRC_Delim_Flag in IDLE: Error_Abort wins; the block stays IDLE.
//  - CRC_Delim_Flag outside IDLE: ignored. No restart.
//  - Reset mid-frame: IDLE on the next edge. No pulses are emitted for the aborted frame.
//  - Counter never wraps. It is cleared on every state entry and saturates unused.
//  - Unused State codes decode to IDLE on the next edge.
// STRUCTURE
//  - State codes and EOF_LEN/IFS_LEN defaults live in the shared CAN defines include
//    (can_defs.vh). The bench and EOF_Error_Block use the same codes.
//  - One natural sub-module: field_bit_counter.
//    - Ports: SP, reset, clear, en, count[CNT_W-1:0], term.
//    - Reusable by the other field stages.
// TESTING
//  - Good tail: CRC_Delim_Flag pulse, then RX = 0,1, then 1 x7, then 1 x3
//    -> EOF_Flag for exactly 1 cycle on the delimiter bit, In_EOF 7 cycles,
//    -> Frame_Done 1 pulse, no error outputs.
//  - ACK missing: ACK slot RX=1, rest as good tail
//    -> ACK_Error 1 pulse; EOF_Flag, In_EOF and Frame_Done still occur.
//  - Bad delimiter: ACK delimiter RX=0
//    -> ACK_Delim_Error pulse, EOF_Flag 0 after that edge, State=IDLE, no In_EOF.
//  - IFS events:
//    - Dominant on IFS bit 2 -> Overload pulse, no Frame_Done.
//    - Dominant on IFS bit 3 -> SOF_Detect pulse, no Frame_Done.
//  - Abort: Error_Abort=1 on 4th EOF bit -> In_EOF 0 next cycle, State=IDLE, no Frame_Done.
//    - Simultaneous Error_Abort and CRC_Delim_Flag in IDLE -> stays IDLE.
//  - Reset: reset=1 in ACK_DELIM -> all outputs 0 and State=IDLE after the edge.
//    - A later clean tail completes normally.

Source files
------------

// File: rtl/ack_eof_sequencer_pkg.sv
// Shared definitions for the CAN frame-tail sequencer: field lengths and state codes.
// The same state codes are used by EOF_Error_Block and the bench.
package ack_eof_sequencer_pkg;

    localparam int EOF_LEN = 7;
    localparam int IFS_LEN = 3;
    localparam int CNT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACK_SLOT  = 3'd1,
        ST_ACK_DELIM = 3'd2,
        ST_EOF       = 3'd3,
        ST_IFS       = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ack_eof_sequencer_if.sv
// Bit-level bus between the CRC stage, the frame-tail sequencer and its consumers.
// The sequencer takes the slave side.
interface ack_eof_sequencer_if;

    logic       RX;
    logic       CRC_Delim_Flag;
    logic       Error_Abort;
    logic       EOF_Flag;
    logic       In_EOF;
    logic       ACK_Error;
    logic       ACK_Delim_Error;
    logic       Overload;
    logic       SOF_Detect;
    logic       Frame_Done;
    logic [2:0] State;

    modport master (
        output RX, CRC_Delim_Flag, Error_Abort,
        input  EOF_Flag, In_EOF, ACK_Error, ACK_Delim_Error,
        input  Overload, SOF_Detect, Frame_Done, State
    );

    modport slave (
        input  RX, CRC_Delim_Flag, Error_Abort,
        output EOF_Flag, In_EOF, ACK_Error, ACK_Delim_Error,
        output Overload, SOF_Detect, Frame_Done, State
    );

endinterface

// File: rtl/ack_eof_sequencer_field_bit_counter.sv
// Bit counter for fixed-length CAN fields; clear wins over enable.
// term flags the all-ones value so the owner can stop counting before a wrap.
module field_bit_counter
    import ack_eof_sequencer_pkg::*;
(
    input  logic             SP,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge SP) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign term  = &r_count;

endmodule

// File: rtl/ack_eof_sequencer.sv
// CAN receive frame-tail sequencer: walks ACK slot, ACK delimiter, EOF and intermission
// on each sample point and reports ACK errors, overload, early SOF and frame completion.
module ack_eof_sequencer
    import ack_eof_sequencer_pkg::*;
(
    input logic SP,
    input logic reset,
    ack_eof_sequencer_if.slave bus
);

    seq_state_t       r_state;
    logic             r_eofFlag;
    logic             r_inEof;
    logic             r_ackError;
    logic             r_ackDelimError;
    logic             r_overload;
    logic             r_sofDetect;
    logic             r_frameDone;

    logic [CNT_W-1:0] w_count;
    logic             w_term;
    logic             w_eofLast;
    logic             w_ifsLast;
    logic             w_advance;
    logic             w_cntClear;
    logic             w_cntEn;

    // The counter only runs while the FSM stays inside EOF or IFS; any exit or entry clears it.
    always_comb begin
        w_eofLast  = (w_count == CNT_W'(EOF_LEN - 1));
        w_ifsLast  = (w_count == CNT_W'(IFS_LEN - 1));
        w_advance  = !bus.Error_Abort &&
                     (((r_state == ST_EOF) && !w_eofLast) ||
                      ((r_state == ST_IFS) && bus.RX && !w_ifsLast));
        w_cntClear = !w_advance;
        w_cntEn    = w_advance && !w_term;
    end

    field_bit_counter u_bitCounter (
        .SP    (SP),
        .reset (reset),
        .clear (w_cntClear),
        .en    (w_cntEn),
        .count (w_count),
        .term  (w_term)
    );

    always_ff @(posedge SP) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_eofFlag       <= 1'b0;
            r_inEof         <= 1'b0;
            r_ackError      <= 1'b0;
            r_ackDelimError <= 1'b0;
            r_overload      <= 1'b0;
            r_sofDetect     <= 1'b0;
            r_frameDone     <= 1'b0;
        end else begin
            r_ackError      <= 1'b0;
            r_ackDelimError <= 1'b0;
            r_overload      <= 1'b0;
            r_sofDetect     <= 1'b0;
            r_frameDone     <= 1'b0;
            if (bus.Error_Abort) begin
                r_state   <= ST_IDLE;
                r_eofFlag <= 1'b0;
                r_inEof   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.CRC_Delim_Flag) begin
                            r_state <= ST_ACK_SLOT;
                        end
                    end
                    // A missing ACK is reported but the tail is still walked.
                    ST_ACK_SLOT: begin
                        r_ackError <= bus.RX;
                        r_eofFlag  <= 1'b1;
                        r_state    <= ST_ACK_DELIM;
                    end
                    ST_ACK_DELIM: begin
                        r_eofFlag <= 1'b0;
                        if (!bus.RX) begin
                            r_ackDelimError <= 1'b1;
                            r_state         <= ST_IDLE;
                        end else begin
                            r_inEof <= 1'b1;
                            r_state <= ST_EOF;
                        end
                    end
                    ST_EOF: begin
                        if (w_eofLast) begin
                            r_inEof <= 1'b0;
                            r_state <= ST_IFS;
                        end
                    end
                    ST_IFS: begin
                        if (!bus.RX) begin
                            r_sofDetect <= w_ifsLast;
                            r_overload  <= !w_ifsLast;
                            r_state     <= ST_IDLE;
                        end else if (w_ifsLast) begin
                            r_frameDone <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_eofFlag <= 1'b0;
                        r_inEof   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.EOF_Flag        = r_eofFlag;
    assign bus.In_EOF          = r_inEof;
    assign bus.ACK_Error       = r_ackError;
    assign bus.ACK_Delim_Error = r_ackDelimError;
    assign bus.Overload        = r_overload;
    assign bus.SOF_Detect      = r_sofDetect;
    assign bus.Frame_Done      = r_frameDone;
    assign bus.State           = r_state;

endmodule
